spk_out_buf: RTL and testbench

Spike output buffer for a neuron node: the receiving end of the work controller's spike-out configuration interface. It captures the neuron coordinate `{z,y,x}` of every neuron the soma reports as fired and queues it in a FIFO. It returns an early-full backpressure flag to the work controller and drains the queue to the node router through a registered valid/ready port.

---
 rtl/spk_out_buf.sv | 100 ++++++++++
 tb/tb_spk_out_buf.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spk_out_buf.sv
// Spike output buffer: queues fired neuron coordinates in a FIFO and drains them
// to the router through a registered valid/ready stage with early-full backpressure.
module spk_out_buf #(
  parameter int unsigned SW     = 24,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4,
  parameter int unsigned MARGIN = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] config_spk_out_neuid,
  input  logic          soma_spk_vld,
  input  logic          soma_spk_fire,
  output logic          spk_out_config_full,
  input  logic          spk_out_clear,
  output logic          spk_out_vld,
  output logic [SW-1:0] spk_out_data,
  input  logic          spk_out_rdy,
  output logic          spk_out_overflow,
  output logic [7:0]    spk_out_drop_cnt,
  output logic          spk_out_empty
);

  localparam int unsigned CW      = AW + 1;
  localparam int unsigned FULL_TH = DEPTH - MARGIN;

  logic [SW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          wr_ev;
  logic          fifo_full;
  logic          wr_ok;
  logic          drop;
  logic          pop;

  // Event decode; clear suppresses every other action in its cycle
  always_comb begin
    wr_ev               = soma_spk_vld && soma_spk_fire;
    fifo_full           = (count == CW'(DEPTH));
    wr_ok               = wr_ev && !fifo_full && !spk_out_clear;
    drop                = wr_ev && fifo_full && !spk_out_clear;
    pop                 = (count != '0) && (!spk_out_vld || spk_out_rdy) && !spk_out_clear;
    spk_out_config_full = (count >= CW'(FULL_TH));
    spk_out_empty       = (count == '0) && !spk_out_vld;
  end

  // Storage array carries no reset; validity is tracked by pointers and count
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= config_spk_out_neuid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      spk_out_vld      <= 1'b0;
      spk_out_data     <= '0;
      spk_out_overflow <= 1'b0;
      spk_out_drop_cnt <= '0;
    end else if (spk_out_clear) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      spk_out_vld      <= 1'b0;
      spk_out_data     <= '0;
      spk_out_overflow <= 1'b0;
      spk_out_drop_cnt <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        spk_out_overflow <= 1'b1;
        if (spk_out_drop_cnt != 8'hFF) begin
          spk_out_drop_cnt <= spk_out_drop_cnt + 8'd1;
        end
      end
      // Output register reloads on pop, empties when consumed with nothing behind it
      if (pop) begin
        spk_out_vld  <= 1'b1;
        spk_out_data <= mem[rd_ptr];
      end else if (spk_out_vld && spk_out_rdy) begin
        spk_out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spk_out_buf.sv
// Directed self-checking bench for spk_out_buf (DEPTH=16, MARGIN=4).
module tb_spk_out_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] config_spk_out_neuid;
  logic        soma_spk_vld;
  logic        soma_spk_fire;
  logic        spk_out_config_full;
  logic        spk_out_clear;
  logic        spk_out_vld;
  logic [23:0] spk_out_data;
  logic        spk_out_rdy;
  logic        spk_out_overflow;
  logic [7:0]  spk_out_drop_cnt;
  logic        spk_out_empty;

  int checks = 0;
  int errors = 0;

  spk_out_buf #(.SW(24), .DEPTH(16), .AW(4), .MARGIN(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .config_spk_out_neuid(config_spk_out_neuid),
    .soma_spk_vld        (soma_spk_vld),
    .soma_spk_fire       (soma_spk_fire),
    .spk_out_config_full (spk_out_config_full),
    .spk_out_clear       (spk_out_clear),
    .spk_out_vld         (spk_out_vld),
    .spk_out_data        (spk_out_data),
    .spk_out_rdy         (spk_out_rdy),
    .spk_out_overflow    (spk_out_overflow),
    .spk_out_drop_cnt    (spk_out_drop_cnt),
    .spk_out_empty       (spk_out_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    soma_spk_vld  = 1'b0;
    soma_spk_fire = 1'b0;
    spk_out_clear = 1'b0;
  endtask

  task automatic fire(input logic [23:0] id);
    soma_spk_vld         = 1'b1;
    soma_spk_fire        = 1'b1;
    config_spk_out_neuid = id;
  endtask

  task automatic do_clear();
    idle();
    spk_out_clear = 1'b1;
    tick();
    spk_out_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    spk_out_rdy = 1'b0;
    config_spk_out_neuid = '0;
    #2;
    checks++; if (spk_out_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b exp 0", spk_out_vld); end
    checks++; if (spk_out_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h exp 000000", spk_out_data); end
    checks++; if (spk_out_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b exp 0", spk_out_overflow); end
    checks++; if (spk_out_drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d exp 0", spk_out_drop_cnt); end
    checks++; if (spk_out_config_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", spk_out_config_full); end
    checks++; if (spk_out_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", spk_out_empty); end
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single();
    spk_out_rdy = 1'b1;
    fire(24'h030201);
    tick();
    idle();
    checks++; if (spk_out_vld !== 1'b0) begin errors++; $display("FAIL single_t1_vld: got %b exp 0", spk_out_vld); end
    checks++; if (spk_out_empty !== 1'b0) begin errors++; $display("FAIL single_t1_empty: got %b exp 0", spk_out_empty); end
    tick();
    checks++; if (spk_out_vld !== 1'b1) begin errors++; $display("FAIL single_t2_vld: got %b exp 1", spk_out_vld); end
    checks++; if (spk_out_data !== 24'h030201) begin errors++; $display("FAIL single_t2_data: got %h exp 030201", spk_out_data); end
    tick();
    checks++; if (spk_out_vld !== 1'b0) begin errors++; $display("FAIL single_t3_vld: got %b exp 0", spk_out_vld); end
    checks++; if (spk_out_empty !== 1'b1) begin errors++; $display("FAIL single_t3_empty: got %b exp 1", spk_out_empty); end
  endtask

  // 20 fires into a stalled port: full threshold, drops, then in-order drain
  task automatic test_fill_stall();
    int exp_cnt;
    int exp_drop;
    int got;
    do_clear();
    spk_out_rdy = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      fire(24'h000100 + 24'(k - 1));
      tick();
      exp_cnt  = (k == 1) ? 1 : ((k - 1 > 16) ? 16 : k - 1);
      exp_drop = (k > 17) ? k - 17 : 0;
      checks++; if (spk_out_config_full !== (exp_cnt >= 12)) begin errors++; $display("FAIL fill_full k=%0d: got %b exp %b", k, spk_out_config_full, exp_cnt >= 12); end
      checks++; if (spk_out_overflow !== (exp_drop != 0)) begin errors++; $display("FAIL fill_ovf k=%0d: got %b exp %b", k, spk_out_overflow, exp_drop != 0); end
      checks++; if (spk_out_drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL fill_drop k=%0d: got %0d exp %0d", k, spk_out_drop_cnt, exp_drop); end
      checks++; if (spk_out_vld !== (k >= 2)) begin errors++; $display("FAIL fill_vld k=%0d: got %b exp %b", k, spk_out_vld, k >= 2); end
      if (k >= 2) begin
        checks++; if (spk_out_data !== 24'h000100) begin errors++; $display("FAIL fill_hold k=%0d: got %h exp 000100", k, spk_out_data); end
      end
    end
    idle();
    spk_out_rdy = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && spk_out_empty !== 1'b1; c++) begin
      if (spk_out_vld === 1'b1) begin
        checks++; if (spk_out_data !== 24'h000100 + 24'(got)) begin errors++; $display("FAIL drain_data n=%0d: got %h exp %h", got, spk_out_data, 24'h000100 + 24'(got)); end
        got++;
      end
      tick();
    end
    checks++; if (got != 17) begin errors++; $display("FAIL drain_count: got %0d exp 17", got); end
    checks++; if (spk_out_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b exp 1", spk_out_empty); end
    checks++; if (spk_out_drop_cnt !== 8'd3) begin errors++; $display("FAIL drain_drop_sticky: got %0d exp 3", spk_out_drop_cnt); end
  endtask

  // 40 ids through a throttled port: order across wraps, stability while stalled
  task automatic test_wrap();
    int          got;
    logic        prev_stall;
    logic [23:0] prev_data;
    do_clear();
    got        = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 200 && got < 40; cyc++) begin
      if (prev_stall) begin
        checks++; if (spk_out_vld !== 1'b1 || spk_out_data !== prev_data) begin errors++; $display("FAIL wrap_stable cyc=%0d: got %b/%h exp 1/%h", cyc, spk_out_vld, spk_out_data, prev_data); end
      end
      if (cyc < 40) fire(24'(cyc));
      else          idle();
      spk_out_rdy = ((cyc % 5) != 0);
      if (spk_out_vld === 1'b1 && spk_out_rdy) begin
        checks++; if (spk_out_data !== 24'(got)) begin errors++; $display("FAIL wrap_order n=%0d: got %h exp %h", got, spk_out_data, 24'(got)); end
        got++;
      end
      prev_stall = (spk_out_vld === 1'b1) && !spk_out_rdy;
      prev_data  = spk_out_data;
      tick();
    end
    idle();
    checks++; if (got != 40) begin errors++; $display("FAIL wrap_count: got %0d exp 40", got); end
    checks++; if (spk_out_overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %b exp 0", spk_out_overflow); end
    checks++; if (spk_out_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b exp 1", spk_out_empty); end
  endtask

  // Queue n_q entries behind a held output, then write+pop in one cycle
  task automatic test_steady(input int n_q);
    logic exp_full;
    do_clear();
    spk_out_rdy = 1'b0;
    for (int i = 0; i <= n_q; i++) begin
      fire(24'h000200 + 24'(i));
      tick();
    end
    idle();
    exp_full = (n_q >= 12);
    checks++; if (spk_out_config_full !== exp_full) begin errors++; $display("FAIL steady%0d_pre_full: got %b exp %b", n_q, spk_out_config_full, exp_full); end
    fire(24'h0002FF);
    spk_out_rdy = 1'b1;
    tick();
    idle();
    spk_out_rdy = 1'b0;
    checks++; if (spk_out_config_full !== exp_full) begin errors++; $display("FAIL steady%0d_full: got %b exp %b", n_q, spk_out_config_full, exp_full); end
    checks++; if (spk_out_vld !== 1'b1 || spk_out_data !== 24'h000201) begin errors++; $display("FAIL steady%0d_data: got %b/%h exp 1/000201", n_q, spk_out_vld, spk_out_data); end
    spk_out_rdy = 1'b1;
    tick();
    spk_out_rdy = 1'b0;
    checks++; if (spk_out_config_full !== (n_q - 1 >= 12)) begin errors++; $display("FAIL steady%0d_post_full: got %b exp %b", n_q, spk_out_config_full, n_q - 1 >= 12); end
    checks++; if (spk_out_data !== 24'h000202) begin errors++; $display("FAIL steady%0d_post_data: got %h exp 000202", n_q, spk_out_data); end
  endtask

  task automatic test_clear_with_fire();
    do_clear();
    spk_out_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      fire(24'h000300 + 24'(i));
      tick();
    end
    idle();
    checks++; if (spk_out_overflow !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf: got %b exp 1", spk_out_overflow); end
    spk_out_rdy = 1'b1;
    repeat (11) tick();
    spk_out_rdy = 1'b0;
    checks++; if (spk_out_vld !== 1'b1 || spk_out_config_full !== 1'b0) begin errors++; $display("FAIL clr_pre_state: got vld %b full %b exp 1 0", spk_out_vld, spk_out_config_full); end
    checks++; if (spk_out_data !== 24'h00030B) begin errors++; $display("FAIL clr_pre_data: got %h exp 00030b", spk_out_data); end
    fire(24'hABCDEF);
    spk_out_clear = 1'b1;
    tick();
    idle();
    checks++; if (spk_out_empty !== 1'b1) begin errors++; $display("FAIL clr_empty: got %b exp 1", spk_out_empty); end
    checks++; if (spk_out_overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b exp 0", spk_out_overflow); end
    checks++; if (spk_out_drop_cnt !== 8'd0) begin errors++; $display("FAIL clr_drop: got %0d exp 0", spk_out_drop_cnt); end
    checks++; if (spk_out_vld !== 1'b0 || spk_out_data !== 24'h0) begin errors++; $display("FAIL clr_out: got %b/%h exp 0/000000", spk_out_vld, spk_out_data); end
    spk_out_rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (spk_out_vld !== 1'b0) begin errors++; $display("FAIL clr_no_emit c=%0d: got %b exp 0", c, spk_out_vld); end
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    spk_out_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      fire(24'h000400 + 24'(i));
      tick();
    end
    idle();
    checks++; if (spk_out_config_full !== 1'b1 || spk_out_overflow !== 1'b1) begin errors++; $display("FAIL arst_pre: got full %b ovf %b exp 1 1", spk_out_config_full, spk_out_overflow); end
    #1 rst = 1'b1;
    #1;
    checks++; if (spk_out_vld !== 1'b0 || spk_out_data !== 24'h0) begin errors++; $display("FAIL arst_out: got %b/%h exp 0/000000", spk_out_vld, spk_out_data); end
    checks++; if (spk_out_overflow !== 1'b0 || spk_out_drop_cnt !== 8'd0) begin errors++; $display("FAIL arst_ovf: got %b/%0d exp 0/0", spk_out_overflow, spk_out_drop_cnt); end
    checks++; if (spk_out_config_full !== 1'b0 || spk_out_empty !== 1'b1) begin errors++; $display("FAIL arst_flags: got full %b empty %b exp 0 1", spk_out_config_full, spk_out_empty); end
    tick();
    rst = 1'b0;
    spk_out_rdy = 1'b1;
    repeat (3) tick();
    checks++; if (spk_out_vld !== 1'b0 || spk_out_empty !== 1'b1) begin errors++; $display("FAIL arst_after: got vld %b empty %b exp 0 1", spk_out_vld, spk_out_empty); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_wrap();
    test_steady(8);
    test_steady(12);
    test_clear_with_fire();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
